// File: rtl/xcvr_8b10b_rx_link_sync.sv
// rtl/xcvr_8b10b_rx_link_sync.sv - per-channel 8B10B RX comma alignment, lock tracking and word qualification
module xcvr_8b10b_rx_link_sync #(
  parameter logic [7:0] COMMA_K       = 8'hBC,
  parameter int         LOCK_COUNT    = 16,
  parameter int         ERR_THRESH    = 4,
  parameter int         ERR_WINDOW    = 256,
  parameter int         ALIGN_TIMEOUT = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        rx_ready,
  input  logic [15:0] rx_parallel_data,
  input  logic [1:0]  rx_datak,
  input  logic [1:0]  rx_syncstatus,
  input  logic [1:0]  rx_errdetect,
  input  logic [1:0]  rx_disperr,
  output logic        rx_std_wa_patternalign,
  output logic [15:0] data_out,
  output logic [1:0]  datak_out,
  output logic        data_valid,
  output logic        link_up,
  output logic        byte_swap,
  output logic [1:0]  link_state,
  output logic [15:0] err_count
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(ERR_WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int TW = $clog2(ALIGN_TIMEOUT);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LIM   = EW'(ERR_THRESH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ALIGN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          swap_q, swap_d;
  logic          pa_q, pa_d;
  logic [15:0]   errc_q, errc_d;

  // Stage A: registered PHY word; stage B: previous stage-A word
  logic [15:0]   a_data_q, a_data_d, b_data_q, b_data_d;
  logic [1:0]    a_k_q, a_k_d, b_k_q, b_k_d;
  logic [1:0]    a_e_q, a_e_d, b_e_q, b_e_d;
  logic [1:0]    a_sync_q, a_sync_d;

  logic [15:0]   dout_q, dout_d;
  logic [1:0]    kout_q, kout_d;
  logic          valid_q, valid_d;

  logic [1:0]    in_e;
  logic [1:0]    al_e;
  logic          al_idle;
  logic          a_werr, comma0, comma1, c_same, c_other, err_inc;

  // Datapath: per-byte error capture, pipeline stages and byte re-pairing
  always_comb begin
    in_e     = rx_errdetect | rx_disperr | ~rx_syncstatus;
    a_data_d = rx_parallel_data;
    a_k_d    = rx_datak;
    a_e_d    = in_e;
    a_sync_d = rx_syncstatus;
    b_data_d = a_data_q;
    b_k_d    = a_k_q;
    b_e_d    = a_e_q;
    // The output flop captures the pairing of the next A and B contents,
    // so data_out always equals align(A, B) of the current cycle.
    if (swap_q) begin
      dout_d = {rx_parallel_data[7:0], a_data_q[15:8]};
      kout_d = {rx_datak[0], a_k_q[1]};
      al_e   = {in_e[0], a_e_q[1]};
    end else begin
      dout_d = a_data_q;
      kout_d = a_k_q;
      al_e   = a_e_q;
    end
    al_idle = (kout_d == 2'b01) && (dout_d[7:0] == COMMA_K);
    valid_d = (state_q == ST_LOCKED) && rx_ready && (al_e == 2'b00) && !al_idle;
  end

  // Link FSM next-state, lock/window counters and error accounting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    werr_d  = werr_q;
    tmr_d   = tmr_q;
    swap_d  = swap_q;
    pa_d    = 1'b0;
    err_inc = 1'b0;
    a_werr  = |a_e_q;
    comma0  = a_k_q[0] && (a_data_q[7:0] == COMMA_K);
    comma1  = a_k_q[1] && (a_data_q[15:8] == COMMA_K);
    c_same  = swap_q ? comma1 : comma0;
    c_other = swap_q ? comma0 : comma1;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          state_d = ST_ALIGN;
          pa_d    = 1'b1;
          tmr_d   = '0;
        end
      end
      ST_ALIGN: begin
        if (a_sync_q == 2'b11) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          pa_d  = 1'b1;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_ACQUIRE: begin
        // Swap reset value is 0, so a first comma in byte1 takes the
        // relatch path and a first comma in byte0 counts from zero.
        if (a_werr) begin
          cnt_d   = '0;
          err_inc = 1'b1;
        end else if (c_same) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LOCK_LAST) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end
        end else if (c_other) begin
          swap_d = ~swap_q;
          cnt_d  = CW'(1);
        end
      end
      default: begin
        err_inc = a_werr;
        if (win_q == WIN_LAST) begin
          win_d  = '0;
          werr_d = EW'(a_werr);
        end else begin
          win_d  = win_q + 1'b1;
          werr_d = werr_q + EW'(a_werr);
        end
        if (werr_d >= ERR_LIM) begin
          state_d = ST_ALIGN;
          pa_d    = 1'b1;
          tmr_d   = '0;
        end
      end
    endcase
    if (!rx_ready) begin
      state_d = ST_IDLE;
      swap_d  = 1'b0;
      pa_d    = 1'b0;
      cnt_d   = '0;
    end
    errc_d = (err_inc && (errc_q != 16'hFFFF)) ? errc_q + 16'd1 : errc_q;
  end

  // All state registers; synchronous reset restores every output to 0
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      tmr_q    <= '0;
      swap_q   <= 1'b0;
      pa_q     <= 1'b0;
      errc_q   <= '0;
      a_data_q <= '0;
      a_k_q    <= '0;
      a_e_q    <= '0;
      a_sync_q <= '0;
      b_data_q <= '0;
      b_k_q    <= '0;
      b_e_q    <= '0;
      dout_q   <= '0;
      kout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      tmr_q    <= tmr_d;
      swap_q   <= swap_d;
      pa_q     <= pa_d;
      errc_q   <= errc_d;
      a_data_q <= a_data_d;
      a_k_q    <= a_k_d;
      a_e_q    <= a_e_d;
      a_sync_q <= a_sync_d;
      b_data_q <= b_data_d;
      b_k_q    <= b_k_d;
      b_e_q    <= b_e_d;
      dout_q   <= dout_d;
      kout_q   <= kout_d;
      valid_q  <= valid_d;
    end
  end

  assign rx_std_wa_patternalign = pa_q;
  assign data_out               = dout_q;
  assign datak_out              = kout_q;
  assign data_valid             = valid_q;
  assign link_up                = (state_q == ST_LOCKED);
  assign byte_swap              = swap_q;
  assign link_state             = state_q;
  assign err_count              = errc_q;

endmodule
